// File: rtl/pipeline_reg_elastic.sv
// Elastic pipeline register: one-entry (SKID_EN=0) or two-entry skid buffer (SKID_EN=1), 1-cycle latency.
// Backpressure: SKID_EN=1 decodes o_ready from state only; SKID_EN=0 passes i_ready through; i_stall freezes everything.
module pipeline_reg_elastic #(
    parameter int DATA_WIDTH = 64,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  accept;
    logic                  drain;

    assign o_valid = (state != EMPTY);
    assign o_data  = main_q;
    assign o_count = state;

    // With the skid entry present, ready must not depend on i_ready so the
    // upstream path is cut; without it, ready has to look ahead at the drain.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign o_ready = ~i_stall & (state != FULL);
        end else begin : g_pass_ready
            assign o_ready = ~i_stall & (~o_valid | i_ready);
        end
    endgenerate

    assign accept = i_valid & o_ready;
    assign drain  = o_valid & i_ready & ~i_stall;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (i_flush) begin
            state <= EMPTY;
        end else if (!i_stall) begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= BUSY;
                        main_q <= i_data;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        main_q <= i_data;
                    end else if (accept && SKID_EN) begin
                        state  <= FULL;
                        skid_q <= i_data;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state  <= BUSY;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_reg_elastic.sv
// Scoreboarded bench for pipeline_reg_elastic in skid (64-bit) and pass-through (8-bit) configurations.
module tb_pipeline_reg_elastic;

    logic        clk = 1'b0;
    logic        arst;
    logic        stall, flush, valid, ready;
    logic [63:0] data;
    logic        o_ready, o_valid;
    logic [63:0] o_data;
    logic [1:0]  o_count;

    logic        n_stall, n_flush, n_valid, n_ready;
    logic [7:0]  n_data;
    logic        n_o_ready, n_o_valid;
    logic [7:0]  n_o_data;
    logic [1:0]  n_o_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sbq[$];
    logic [63:0] exp_d;

    always #5 clk = ~clk;

    pipeline_reg_elastic #(.DATA_WIDTH(64), .SKID_EN(1'b1)) dut (
        .i_clk(clk), .i_arst(arst), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_data(data), .o_ready(o_ready), .o_valid(o_valid),
        .o_data(o_data), .i_ready(ready), .o_count(o_count)
    );

    pipeline_reg_elastic #(.DATA_WIDTH(8), .SKID_EN(1'b0)) dut_n (
        .i_clk(clk), .i_arst(arst), .i_stall(n_stall), .i_flush(n_flush),
        .i_valid(n_valid), .i_data(n_data), .o_ready(n_o_ready), .o_valid(n_o_valid),
        .o_data(n_o_data), .i_ready(n_ready), .o_count(n_o_count)
    );

    // Scoreboard: push on accept, pop and compare on drain; flush/reset discard.
    always @(negedge clk) begin
        if (arst || flush) begin
            sbq.delete();
        end else begin
            if (o_valid && ready && !stall) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got o_data=%h, expected no output", o_data);
                end else begin
                    exp_d = sbq.pop_front();
                    if (o_data !== exp_d) begin
                        errors++;
                        $display("FAIL sb_order: o_data=%h expected=%h", o_data, exp_d);
                    end
                end
            end
            if (valid && o_ready) sbq.push_back(data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_full();
        ready = 1'b0; valid = 1'b1; data = 64'h11;
        cyc();
        data = 64'h22;
        cyc();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; valid = 1'b1; ready = 1'b0; data = 64'hDEAD; flush = 1'b0; stall = 1'b0;
        n_valid = 1'b0; n_ready = 1'b0; n_data = 8'h0; n_flush = 1'b0; n_stall = 1'b0;
        cyc(); cyc();
        arst = 1'b0; valid = 1'b0; stall = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_count !== 2'd0 || o_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d data=%h, expected 0/0/0", o_valid, o_count, o_data);
        end
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_stalled: o_ready=%b expected 0", o_ready);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_free: o_ready=%b expected 1", o_ready);
        end
        cyc();
    endtask

    task automatic test_single();
        valid = 1'b1; ready = 1'b1; data = 64'hA5;
        cyc();
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 64'hA5 || o_count !== 2'd1) begin
            errors++;
            $display("FAIL single_out: valid=%b data=%h count=%0d, expected 1/a5/1", o_valid, o_data, o_count);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_gone: o_valid=%b expected 0", o_valid);
        end
        cyc();
    endtask

    task automatic test_skid();
        fill_full();
        @(negedge clk);
        checks++;
        if (o_count !== 2'd2 || o_ready !== 1'b0 || o_data !== 64'h11) begin
            errors++;
            $display("FAIL skid_full: count=%0d ready=%b data=%h, expected 2/0/11", o_count, o_ready, o_data);
        end
        cyc();
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_data !== 64'h11) begin
            errors++;
            $display("FAIL skid_first: data=%h expected 11", o_data);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (o_data !== 64'h22 || o_count !== 2'd1) begin
            errors++;
            $display("FAIL skid_second: data=%h count=%0d expected 22/1", o_data, o_count);
        end
        cyc();
        checks++;
        if (o_valid !== 1'b0 || o_count !== 2'd0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL skid_empty: valid=%b count=%0d pending=%0d expected 0/0/0", o_valid, o_count, sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int nout = 0;
        int gaps = 0;
        ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) begin
                valid = 1'b1;
                data  = 64'h1000 + 64'(i);
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
            if (valid && o_ready) acc++;
            if (o_valid) nout++;
            else if (nout > 0 && nout < 100) gaps++;
            cyc();
        end
        checks++;
        if (acc != 100 || nout != 100 || gaps != 0) begin
            errors++;
            $display("FAIL b2b_throughput: accepts=%0d outputs=%0d gaps=%0d expected 100/100/0", acc, nout, gaps);
        end
        checks++;
        if (o_valid !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_drained: valid=%b pending=%0d expected 0/0", o_valid, sbq.size());
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        fill_full();
        stall = 1'b1; ready = 1'b1; valid = 1'b1; data = 64'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_data !== 64'h11 || o_count !== 2'd2 || o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad cycles, data=%h count=%0d ready=%b, expected 11/2/0", bad, o_data, o_count, o_ready);
        end
        stall = 1'b0; valid = 1'b0;
        cyc(); cyc();
        checks++;
        if (o_valid !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL stall_release: valid=%b pending=%0d expected 0/0", o_valid, sbq.size());
        end
    endtask

    task automatic test_flush();
        fill_full();
        flush = 1'b1; stall = 1'b1; valid = 1'b1; ready = 1'b1; data = 64'h44;
        cyc();
        flush = 1'b0; stall = 1'b0; valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_count !== 2'd0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state: valid=%b count=%0d ready=%b expected 0/0/1", o_valid, o_count, o_ready);
        end
        checks++;
        if (o_data !== 64'h11) begin
            errors++;
            $display("FAIL flush_data_kept: data=%h expected 11", o_data);
        end
        cyc();
    endtask

    task automatic test_reset_full();
        fill_full();
        arst = 1'b1; ready = 1'b1; valid = 1'b1; data = 64'h55;
        cyc();
        arst = 1'b0; valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || o_count !== 2'd0 || o_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_full: valid=%b count=%0d data=%h expected 0/0/0", o_valid, o_count, o_data);
        end
        cyc();
    endtask

    task automatic test_noskid();
        int bad_rdy = 0;
        int bad_cnt = 0;
        n_valid = 1'b1; n_ready = 1'b0; n_data = 8'h05;
        cyc();
        for (int k = 0; k < 10; k++) begin
            n_ready = k[0];
            n_data  = 8'(8'h10 + k);
            @(negedge clk);
            if (n_o_valid !== 1'b1 || n_o_ready !== n_ready) bad_rdy++;
            if (n_o_count > 2'd1) bad_cnt++;
            cyc();
        end
        n_valid = 1'b0;
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL noskid_ready_track: %0d cycles where o_ready did not follow i_ready", bad_rdy);
        end
        checks++;
        if (bad_cnt != 0) begin
            errors++;
            $display("FAIL noskid_count: %0d cycles with o_count above 1", bad_cnt);
        end
    endtask

    initial begin
        arst = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
        n_stall = 1'b0; n_flush = 1'b0; n_valid = 1'b0; n_ready = 1'b0; n_data = '0;
        test_reset();
        test_single();
        test_skid();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_full();
        test_noskid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_reg_elastic.md
PIPELINE_REG_ELASTIC -- requirements
Module: pipeline_reg_elastic

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 64: payload width in bits.
REQ-002 SHALL provide parameter SKID_EN, default 1: 1 = two-entry skid buffer with registered ready; 0 = single-entry register with pass-through ready.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL provide ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_arst  input  1  synchronous, active-high reset.
- i_stall  input  1  freeze: hold all state; no accept, no drain.
- i_flush  input  1  discard all held entries.
- i_valid  input  1  upstream payload valid.
- i_data  input  DATA_WIDTH  upstream payload.
- o_ready  output  1  block can accept this cycle.
- o_valid  output  1  o_data holds a valid entry.
- o_data  output  DATA_WIDTH  oldest held payload.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_count  output  2  number of held entries, 0..2.

Function
REQ-005 SHALL define accept = i_valid & o_ready and drain = o_valid & i_ready & ~i_stall.
REQ-006 SHALL hold entries in a main register driving o_data and, when SKID_EN=1, one skid register.
REQ-007 SHALL implement states EMPTY (0 entries), BUSY (main only) and FULL (main + skid), with o_count equal to 0, 1 and 2 respectively.
REQ-008 With SKID_EN=1, o_ready SHALL be ~i_stall & (state != FULL), decoded from state only with no combinational path from i_ready.
REQ-009 With SKID_EN=0, o_ready SHALL be ~i_stall & (~o_valid | i_ready), and FULL SHALL be unreachable.
REQ-010 SHALL drive o_valid = 1 exactly in BUSY and FULL.
REQ-011 SHALL apply these transitions when not flushed and not stalled:
- EMPTY + accept -> BUSY, with main <= i_data.
- BUSY + accept & drain -> BUSY, with main <= i_data.
- BUSY + accept & ~drain -> FULL, with skid <= i_data (SKID_EN=1 only).
- BUSY + ~accept & drain -> EMPTY.
- FULL + drain -> BUSY, with main <= skid.
- FULL + ~drain -> FULL, holding both registers.
REQ-012 No input SHALL be accepted in FULL; the FULL + drain transition SHALL NOT load i_data in the same cycle.
REQ-013 Payload order SHALL be strictly FIFO; no entry SHALL be duplicated or lost except by flush or reset.
REQ-014 i_stall=1 SHALL hold state, main, skid and o_count, force o_ready=0, and keep o_valid and o_data stable regardless of i_ready.
REQ-015 i_flush=1 SHALL take state to EMPTY at the next edge, discarding all entries and any same-cycle accept.
REQ-016 Flush SHALL take priority over i_stall, i_valid and i_ready.
REQ-017 Flush SHALL leave the main and skid data registers unchanged; only valid status is cleared.
REQ-018 o_data SHALL remain stable while o_valid=1 and drain=0.
REQ-019 Latency SHALL be one cycle from accept into EMPTY to o_valid=1, with no combinational path from i_data to o_data.
REQ-020 Sustained throughput SHALL be one entry per cycle while i_valid=1 and i_ready=1.

Reset
REQ-021 i_arst=1 at a rising edge SHALL set state EMPTY, o_valid 0, o_count 0, and main, skid and o_data all 0.
REQ-022 Reset SHALL have priority over i_flush, i_stall and every handshake input.
REQ-023 Reset asserted mid-operation SHALL discard all entries, including an entry in FULL, with no partial drain.
REQ-024 In the first cycle after reset release, o_ready SHALL equal ~i_stall.

Verification
REQ-025 Reset then i_valid=1, i_data=0xA5, i_ready=1 for one cycle -> next cycle o_valid=1, o_data=0xA5, o_count=1; the following cycle o_valid=0.
REQ-026 SKID_EN=1, i_ready=0, push 0x11 then 0x22 -> o_count=2, o_ready=0, o_data=0x11; raise i_ready -> outputs 0x11 then 0x22 on successive cycles, then EMPTY.
REQ-027 Continuous i_valid=i_ready=1 with an incrementing payload over 100 cycles -> 100 outputs, in order, one per cycle, with no gaps after the first.
REQ-028 FULL state with i_stall=1 and i_ready=1 for 3 cycles -> o_data stays 0x11, o_count stays 2, o_ready=0; after release, normal drain.
REQ-029 FULL state with i_flush=1, i_stall=1 and i_valid=1 -> next cycle o_valid=0, o_count=0, o_ready=1 (stall released).
REQ-030 SKID_EN=0 with o_valid=1 and i_ready toggling -> o_ready tracks i_ready in the same cycle, and o_count never exceeds 1.
